// File: rtl/draw_image_rect.sv
// draw_image_rect: overlays a 48x64 ROM image on the pixel stream at (xpos, ypos).
// Optional macro DRAW_IMAGE_TRANSPARENT_EN enables KEY_RGB colour-keyed transparency.
//
// Ports:
//   clk, rst_n            pixel clock, asynchronous active-low reset
//   xpos, ypos            rectangle top-left corner, latched at frame start
//   hcount_in, vcount_in  pixel counters from the timing chain
//   hsync/vsync/hblnk/vblnk_in, rgb_in   timing strobes and background colour
//   pixel_addr            ROM address {y_rel[5:0], x_rel[5:0]}
//   rgb_pixel             ROM data, valid one cycle after pixel_addr
//   *_out                 all inputs delayed 3 cycles, rgb_out composed colour
module draw_image_rect #(
    parameter int          IMG_W   = 48,
    parameter int          IMG_H   = 64,
    parameter logic [11:0] KEY_RGB = 12'h0F0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] xpos,
    input  logic [10:0] ypos,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    output logic [11:0] pixel_addr,
    input  logic [11:0] rgb_pixel,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out
);

`ifdef DRAW_IMAGE_TRANSPARENT_EN
    localparam logic TRANSP = 1'b1;
`else
    localparam logic TRANSP = 1'b0;
`endif

    logic [10:0] xpos_l, ypos_l;

    // 12-bit compares so the right/bottom edge never wraps past 2047
    logic [11:0] h12, v12, xl12, yl12, xe12, ye12;
    logic        in_rect;
    logic [5:0]  x_rel, y_rel;
    logic        frame_start;

    assign h12  = {1'b0, hcount_in};
    assign v12  = {1'b0, vcount_in};
    assign xl12 = {1'b0, xpos_l};
    assign yl12 = {1'b0, ypos_l};
    assign xe12 = xl12 + 12'(IMG_W);
    assign ye12 = yl12 + 12'(IMG_H);

    assign in_rect = (h12 >= xl12) && (h12 < xe12) &&
                     (v12 >= yl12) && (v12 < ye12);

    // low 6 bits of the difference depend only on the low 6 bits
    assign x_rel = hcount_in[5:0] - xpos_l[5:0];
    assign y_rel = vcount_in[5:0] - ypos_l[5:0];

    assign frame_start = (hcount_in == 11'd0) && (vcount_in == 11'd0);

    // stage 1 delay registers
    logic [10:0] d1_hcount, d1_vcount;
    logic        d1_hsync, d1_vsync, d1_hblnk, d1_vblnk, d1_in_rect;
    logic [11:0] d1_rgb;

    // stage 2 delay registers
    logic [10:0] d2_hcount, d2_vcount;
    logic        d2_hsync, d2_vsync, d2_hblnk, d2_vblnk, d2_in_rect;
    logic [11:0] d2_rgb;

    logic [11:0] rgb_nxt;
    logic        show_bg;

    // position latch; the frame-start pixel itself still uses the old values
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xpos_l <= '0;
            ypos_l <= '0;
        end else if (frame_start) begin
            xpos_l <= xpos;
            ypos_l <= ypos;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_addr <= '0;
            d1_hcount  <= '0;
            d1_vcount  <= '0;
            d1_hsync   <= 1'b0;
            d1_vsync   <= 1'b0;
            d1_hblnk   <= 1'b0;
            d1_vblnk   <= 1'b0;
            d1_in_rect <= 1'b0;
            d1_rgb     <= '0;
        end else begin
            if (in_rect)
                pixel_addr <= {y_rel, x_rel};
            d1_hcount  <= hcount_in;
            d1_vcount  <= vcount_in;
            d1_hsync   <= hsync_in;
            d1_vsync   <= vsync_in;
            d1_hblnk   <= hblnk_in;
            d1_vblnk   <= vblnk_in;
            d1_in_rect <= in_rect;
            d1_rgb     <= rgb_in;
        end
    end

    // stage 2 lines up with the external ROM register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d2_hcount  <= '0;
            d2_vcount  <= '0;
            d2_hsync   <= 1'b0;
            d2_vsync   <= 1'b0;
            d2_hblnk   <= 1'b0;
            d2_vblnk   <= 1'b0;
            d2_in_rect <= 1'b0;
            d2_rgb     <= '0;
        end else begin
            d2_hcount  <= d1_hcount;
            d2_vcount  <= d1_vcount;
            d2_hsync   <= d1_hsync;
            d2_vsync   <= d1_vsync;
            d2_hblnk   <= d1_hblnk;
            d2_vblnk   <= d1_vblnk;
            d2_in_rect <= d1_in_rect;
            d2_rgb     <= d1_rgb;
        end
    end

    assign show_bg = TRANSP && (rgb_pixel == KEY_RGB);

    always_comb begin
        rgb_nxt = d2_rgb;
        if (d2_hblnk || d2_vblnk)
            rgb_nxt = 12'h000;
        else if (d2_in_rect && !show_bg)
            rgb_nxt = rgb_pixel;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcount_out <= '0;
            vcount_out <= '0;
            hsync_out  <= 1'b0;
            vsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= '0;
        end else begin
            hcount_out <= d2_hcount;
            vcount_out <= d2_vcount;
            hsync_out  <= d2_hsync;
            vsync_out  <= d2_vsync;
            hblnk_out  <= d2_hblnk;
            vblnk_out  <= d2_vblnk;
            rgb_out    <= rgb_nxt;
        end
    end

endmodule

// File: tb/tb_draw_image_rect.sv
// tb_draw_image_rect: directed vectors plus streaming and reset sequences
// for draw_image_rect, with a one-cycle-latency ROM model.
module tb_draw_image_rect;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] xpos = '0, ypos = '0;
    logic [10:0] hcount_in = '0, vcount_in = '0;
    logic        hsync_in = 1'b0, vsync_in = 1'b0;
    logic        hblnk_in = 1'b0, vblnk_in = 1'b0;
    logic [11:0] rgb_in = '0;
    logic [11:0] pixel_addr;
    logic [11:0] rgb_pixel;
    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
    logic [11:0] rgb_out;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    draw_image_rect dut (
        .clk(clk), .rst_n(rst_n),
        .xpos(xpos), .ypos(ypos),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
        .rgb_in(rgb_in),
        .pixel_addr(pixel_addr), .rgb_pixel(rgb_pixel),
        .hcount_out(hcount_out), .vcount_out(vcount_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out),
        .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
        .rgb_out(rgb_out)
    );

    // ROM image: word 0 is the key colour, everything else a scramble
    function automatic logic [11:0] rom(input logic [11:0] a);
        return (a == 12'h000) ? 12'h0F0 : (a ^ 12'hA5A);
    endfunction

    always_ff @(posedge clk)
        rgb_pixel <= rom(pixel_addr);

    task automatic chk(input string nm, input int idx,
                       input logic [11:0] act, input logic [11:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    // expected colour for a drawn ROM word, accounting for the key option
    function automatic logic [11:0] drawn(input logic [11:0] w,
                                          input logic [11:0] bg);
`ifdef DRAW_IMAGE_TRANSPARENT_EN
        return (w == 12'h0F0) ? bg : w;
`else
        return (bg == bg) ? w : w;
`endif
    endfunction

    typedef struct {
        logic [10:0] h, v, xp, yp;
        logic        hb, vb;
        logic [11:0] rgb;
        logic [11:0] addr;
        logic        drw;
        logic [11:0] col;
    } vec_t;

    vec_t tv[19];

    task automatic setv(input int i, input int h, input int v,
                        input int xp, input int yp,
                        input bit hb, input bit vb, input int rgb,
                        input int addr, input bit drw, input int col);
        tv[i].h = 11'(h);   tv[i].v = 11'(v);
        tv[i].xp = 11'(xp); tv[i].yp = 11'(yp);
        tv[i].hb = hb;      tv[i].vb = vb;
        tv[i].rgb = 12'(rgb);
        tv[i].addr = 12'(addr);
        tv[i].drw = drw;
        tv[i].col = 12'(col);
    endtask

    task automatic drive(input logic [10:0] h, input logic [10:0] v,
                         input logic hb, input logic vb,
                         input logic [11:0] rgb);
        hcount_in = h;
        vcount_in = v;
        hsync_in  = h[0];
        vsync_in  = v[1];
        hblnk_in  = hb;
        vblnk_in  = vb;
        rgb_in    = rgb;
    endtask

    logic [11:0] exp_rgb;
    logic [10:0] hq[$];

    initial begin
        // h, v, xp, yp, hb, vb, rgb, addr, drawn?, colour
        setv(0,    0,   0, 100,  50, 0, 0, 'h123, 'h000, 1, 'h0F0);
        setv(1,  100,  50, 100,  50, 0, 0, 'h456, 'h000, 1, 'h0F0);
        setv(2,  147, 113, 100,  50, 0, 0, 'h789, 'hFEF, 1, 'h5B5);
        setv(3,  148, 113, 100,  50, 0, 0, 'h321, 'hFEF, 0, 'h321);
        setv(4,  147, 114, 100,  50, 0, 0, 'h654, 'hFEF, 0, 'h654);
        setv(5,   99,  50, 100,  50, 0, 0, 'h111, 'hFEF, 0, 'h111);
        setv(6,  120,  60, 100,  50, 0, 0, 'h9AB, 'h294, 1, 'h8CE);
        setv(7,  110,  60, 300,  50, 0, 0, 'hCDE, 'h28A, 1, 'h8D0);
        setv(8,    0,   0, 300,  50, 1, 0, 'hFFF, 'h28A, 0, 'h000);
        setv(9,  100,  50, 300,  50, 0, 0, 'h222, 'h28A, 0, 'h222);
        setv(10, 300,  50, 300,  50, 0, 0, 'h333, 'h000, 1, 'h0F0);
        setv(11, 310,  52, 300,  50, 0, 0, 'h3A3, 'h08A, 1, 'hAD0);
        setv(12,   0,   0, 790,   0, 0, 1, 'hEEE, 'h08A, 0, 'h000);
        setv(13, 795,  10, 790,   0, 0, 0, 'h444, 'h285, 1, 'h8DF);
        setv(14, 800,  10, 790,   0, 1, 0, 'h4A4, 'h28A, 0, 'h000);
        setv(15, 837,  63, 790,   0, 1, 0, 'h4B4, 'hFEF, 0, 'h000);
        setv(16,   0,   0, 2040,  0, 0, 1, 'h777, 'hFEF, 0, 'h000);
        setv(17, 2047,  5, 2040,  0, 0, 0, 'h555, 'h147, 1, 'hB1D);
        setv(18,   5,   5, 2040,  0, 0, 0, 'h666, 'h147, 0, 'h666);

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_addr", 0, pixel_addr, 12'h000);
        chk("rst_rgb", 0, rgb_out, 12'h000);
        chk("rst_hcnt", 0, 12'(hcount_out), 12'h000);
        rst_n = 1'b1;

        // table: hold each vector for 3 edges, then compare
        for (int i = 0; i < 19; i++) begin
            xpos = tv[i].xp;
            ypos = tv[i].yp;
            drive(tv[i].h, tv[i].v, tv[i].hb, tv[i].vb, tv[i].rgb);
            @(posedge clk);
            #1;
            chk("addr", i, pixel_addr, tv[i].addr);
            repeat (2) @(posedge clk);
            #1;
            exp_rgb = tv[i].drw ? drawn(tv[i].col, tv[i].rgb) : tv[i].col;
            chk("rgb", i, rgb_out, exp_rgb);
            chk("hcnt", i, 12'(hcount_out), 12'(tv[i].h));
            chk("vcnt", i, 12'(vcount_out), 12'(tv[i].v));
            chk("strb", i,
                {8'd0, hsync_out, vsync_out, hblnk_out, vblnk_out},
                {8'd0, tv[i].h[0], tv[i].v[1], tv[i].hb, tv[i].vb});
        end

        // streaming: one pixel per cycle along line 5 across x=2037..2047
        for (int i = 0; i < 11; i++) begin
            drive(11'(2037 + i), 11'd5, 1'b0, 1'b0, 12'(2037 + i));
            hq.push_back(11'(2037 + i));
            @(posedge clk);
            #1;
            if (i >= 3)
                chk("s_addr", i, pixel_addr, 12'h140 + 12'(i - 3));
            if (i >= 2) begin
                logic [10:0] ho;
                ho = hq.pop_front();
                chk("s_hcnt", i, 12'(hcount_out), 12'(ho));
                exp_rgb = (ho >= 11'd2040) ?
                          drawn(rom(12'h140 + 12'(ho - 11'd2040)), 12'(ho)) :
                          12'(ho);
                chk("s_rgb", i, rgb_out, exp_rgb);
            end
        end

        // asynchronous reset mid-stream clears everything at once
        #2 rst_n = 1'b0;
        #1;
        chk("ar_addr", 0, pixel_addr, 12'h000);
        chk("ar_rgb", 0, rgb_out, 12'h000);
        chk("ar_hcnt", 0, 12'(hcount_out), 12'h000);
        chk("ar_strb", 0, {8'd0, hsync_out, vsync_out, hblnk_out, vblnk_out},
            12'h000);
        @(posedge clk);
        #1;
        chk("ar_hold", 0, rgb_out, 12'h000);
        rst_n = 1'b1;

        // latch cleared to (0,0): pixel (10,20) maps to {20,10}
        xpos = 11'd500;
        ypos = 11'd500;
        drive(11'd10, 11'd20, 1'b0, 1'b0, 12'h0AB);
        @(posedge clk);
        #1;
        chk("pr_addr", 0, pixel_addr, 12'h50A);
        repeat (2) @(posedge clk);
        #1;
        chk("pr_rgb", 0, rgb_out, 12'hF50);
        chk("pr_hcnt", 0, 12'(hcount_out), 12'd10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
